// File: rtl/led_panel_pkg.sv
// Shared definitions for the HUB75 BCM scan controller: FSM encoding and plane-select width.
// No logic; purely types and constants.
// Not applicable (no datapath, no flow control).
package led_panel_pkg;

    // Bit-plane select into mux_led is fixed at 2 bits (4 planes per colour).
    localparam int PLANE_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_LATCH   = 3'd2,
        ST_DISPLAY = 3'd3,
        ST_NEXT    = 3'd4
    } scan_state_e;

endpackage

// File: rtl/bcm_disp_timer.sv
// BCM display timer: loads BASE_TIME<<plane and counts down while enabled.
// done is combinational in the last enabled cycle, so the caller sees exactly N enabled cycles.
// No backpressure; en simply freezes the count.
module bcm_disp_timer
    import led_panel_pkg::*;
#(
    parameter int BASE_TIME = 8,
    parameter int DISP_W    = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [PLANE_W-1:0] plane,
    input  logic               en,
    output logic               done
);

    logic [DISP_W-1:0] cnt_q, cnt_d;

    // Next count: reload on load, otherwise decrement while enabled and non-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = DISP_W'(BASE_TIME) << plane;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = en && (cnt_q == DISP_W'(1));

endmodule

// File: rtl/led_bcm_scan_ctrl.sv
// HUB75 BCM scan controller: per row and bit-plane, shift COLS pixels, latch, display BASE_TIME<<plane.
// Latency: mem_addr/plane_sel/row_addr registered; panel pins decoded from the registered state.
// No backpressure; enable is sampled only in IDLE and NEXT, so a plane in flight always completes.
module led_bcm_scan_ctrl
    import led_panel_pkg::*;
#(
    parameter int COLS      = 64,
    parameter int ROWS      = 16,
    parameter int BPP       = 4,
    parameter int BASE_TIME = 8,
    localparam int COL_W    = $clog2(COLS),
    localparam int ROW_W    = $clog2(ROWS),
    localparam int DISP_W   = $clog2(BASE_TIME << (BPP - 1)) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    output logic [ROW_W+COL_W-1:0] mem_addr,
    output logic [PLANE_W-1:0]     plane_sel,
    output logic [ROW_W-1:0]       row_addr,
    output logic                   panel_clk,
    output logic                   panel_lat,
    output logic                   panel_oe_n,
    output logic                   frame_done,
    output logic                   busy
);

    // Shift cycle counter runs 0..2*COLS, which needs one bit above the column index.
    localparam int                T_W        = COL_W + 2;
    localparam logic [T_W-1:0]    T_LAST     = T_W'(2 * COLS);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(BPP - 1);

    scan_state_e              state_q, state_d;
    logic [T_W-1:0]           t_q, t_d, t_inc;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [PLANE_W-1:0]       plane_q, plane_d;
    logic [ROW_W-1:0]         row_addr_q, row_addr_d;
    logic [ROW_W+COL_W-1:0]   mem_addr_q, mem_addr_d;
    logic                     timer_load, timer_en, timer_done;

    assign t_inc = t_q + 1'b1;

    // Next-state, counters and pin decode; mem_addr is precomputed one cycle ahead.
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        row_d      = row_q;
        plane_d    = plane_q;
        row_addr_d = row_addr_q;
        mem_addr_d = mem_addr_q;
        panel_clk  = 1'b0;
        panel_lat  = 1'b0;
        panel_oe_n = 1'b1;
        frame_done = 1'b0;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_SHIFT;
                    t_d        = '0;
                    mem_addr_d = {row_q, {COL_W{1'b0}}};
                end
            end
            ST_SHIFT: begin
                // Rising shift clock one cycle after RAM data for column k becomes valid.
                panel_clk = (t_q != '0) && !t_q[0];
                if (t_q == T_LAST) begin
                    state_d = ST_LATCH;
                end else begin
                    t_d        = t_inc;
                    mem_addr_d = {row_q, t_inc[COL_W:1]};
                end
            end
            ST_LATCH: begin
                // Row lines move only here, while OE is still blanked.
                panel_lat  = 1'b1;
                row_addr_d = row_q;
                timer_load = 1'b1;
                state_d    = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                panel_oe_n = 1'b0;
                timer_en   = 1'b1;
                if (timer_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                plane_d = plane_q + 1'b1;
                if (plane_q == LAST_PLANE) begin
                    plane_d = '0;
                    row_d   = row_q + 1'b1;
                    if (row_q == LAST_ROW) begin
                        frame_done = 1'b1;
                    end
                end
                if (enable) begin
                    state_d    = ST_SHIFT;
                    t_d        = '0;
                    mem_addr_d = {row_d, {COL_W{1'b0}}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            t_q        <= '0;
            row_q      <= '0;
            plane_q    <= '0;
            row_addr_q <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            row_q      <= row_d;
            plane_q    <= plane_d;
            row_addr_q <= row_addr_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    bcm_disp_timer #(
        .BASE_TIME (BASE_TIME),
        .DISP_W    (DISP_W)
    ) u_disp_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .plane (plane_q),
        .en    (timer_en),
        .done  (timer_done)
    );

    assign mem_addr  = mem_addr_q;
    assign plane_sel = plane_q;
    assign row_addr  = row_addr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_bcm_scan_ctrl.sv
// Bench for led_bcm_scan_ctrl with COLS=4, ROWS=2, BASE_TIME=4, 1-cycle RAM and mux_led model.
// Inputs driven 1 time unit after posedge; outputs sampled at the same point.
// Table-driven shift/display checks plus hand sequences for frame, pause/resume and reset.
module tb_led_bcm_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [2:0] mem_addr;
    logic [1:0] plane_sel;
    logic [0:0] row_addr;
    logic       panel_clk, panel_lat, panel_oe_n, frame_done, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_bcm_scan_ctrl #(
        .COLS      (4),
        .ROWS      (2),
        .BPP       (4),
        .BASE_TIME (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mem_addr   (mem_addr),
        .plane_sel  (plane_sel),
        .row_addr   (row_addr),
        .panel_clk  (panel_clk),
        .panel_lat  (panel_lat),
        .panel_oe_n (panel_oe_n),
        .frame_done (frame_done),
        .busy       (busy)
    );

    // Frame buffer (12bpp: R[11:8] G[7:4] B[3:0]), 1-cycle read latency, then mux_led.
    logic [11:0] fb [8];
    logic [11:0] ram_q;
    logic [2:0]  rgb;
    always_ff @(posedge clk) ram_q <= fb[mem_addr];
    assign rgb = {ram_q[8 + plane_sel], ram_q[4 + plane_sel], ram_q[plane_sel]};

    function automatic logic [2:0] pix(input int addr, input int p);
        logic [11:0] w;
        w = fb[addr];
        return {w[8 + p], w[4 + p], w[p]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for OE to go low, then counts its low cycles; ends on the first OE-high cycle.
    task automatic measure(output int len, output logic [1:0] ps, output logic [0:0] ra);
        int guard;
        guard = 0;
        len   = 0;
        while (panel_oe_n === 1'b1 && guard < 400) begin
            step();
            guard++;
        end
        ps = plane_sel;
        ra = row_addr;
        while (panel_oe_n === 1'b0 && len < 100) begin
            len++;
            step();
        end
    endtask

    typedef struct {
        logic       en;
        logic       chk_addr;
        logic [2:0] addr;
        logic       pclk;
        logic       lat;
        int         col;
    } shift_vec_t;

    typedef struct {
        logic       en;
        int         len;
        logic [1:0] ps;
        logic [0:0] ra;
    } disp_vec_t;

    shift_vec_t shift_tbl [10];
    disp_vec_t  disp_tbl  [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          len, n, guard;
        logic [1:0]  ps;
        logic [0:0]  ra;

        for (int i = 0; i < 8; i++) fb[i] = 12'((i * 12'h35B) ^ 12'hA5C);

        // SHIFT t=0..8 then LATCH t=9; col = column whose pixel is shifted on this panel_clk.
        shift_tbl[0] = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, -1};
        shift_tbl[1] = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, -1};
        shift_tbl[2] = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b0,  0};
        shift_tbl[3] = '{1'b1, 1'b1, 3'd1, 1'b0, 1'b0, -1};
        shift_tbl[4] = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b0,  1};
        shift_tbl[5] = '{1'b1, 1'b1, 3'd2, 1'b0, 1'b0, -1};
        shift_tbl[6] = '{1'b1, 1'b1, 3'd3, 1'b1, 1'b0,  2};
        shift_tbl[7] = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0, -1};
        shift_tbl[8] = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0,  3};
        shift_tbl[9] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b1, -1};

        disp_tbl[0] = '{1'b1,  4, 2'd0, 1'b0};
        disp_tbl[1] = '{1'b1,  8, 2'd1, 1'b0};
        disp_tbl[2] = '{1'b1, 16, 2'd2, 1'b0};
        disp_tbl[3] = '{1'b1, 32, 2'd3, 1'b0};
        disp_tbl[4] = '{1'b1,  4, 2'd0, 1'b1};

        // Reset state, and IDLE holds while enable stays low.
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) step();
        chk("rst mem_addr",   mem_addr,   0);
        chk("rst plane_sel",  plane_sel,  0);
        chk("rst row_addr",   row_addr,   0);
        chk("rst panel_clk",  panel_clk,  0);
        chk("rst panel_lat",  panel_lat,  0);
        chk("rst panel_oe_n", panel_oe_n, 1);
        chk("rst frame_done", frame_done, 0);
        chk("rst busy",       busy,       0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle hold busy/oe_n/clk", {busy, panel_oe_n, panel_clk}, 3'b010);
        end

        // First SHIFT + LATCH of row 0, plane 0.
        enable = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            enable = shift_tbl[i].en;
            chk($sformatf("shift t=%0d panel_clk", i), panel_clk, shift_tbl[i].pclk);
            chk($sformatf("shift t=%0d panel_lat", i), panel_lat, shift_tbl[i].lat);
            chk($sformatf("shift t=%0d oe_n", i), panel_oe_n, 1);
            if (shift_tbl[i].chk_addr)
                chk($sformatf("shift t=%0d mem_addr", i), mem_addr, shift_tbl[i].addr);
            if (shift_tbl[i].col >= 0)
                chk($sformatf("shift t=%0d rgb", i), rgb, pix(shift_tbl[i].col, 0));
            step();
        end

        // Display lengths per plane, then row 1 after plane 3.
        for (int i = 0; i < 5; i++) begin
            enable = disp_tbl[i].en;
            measure(len, ps, ra);
            chk($sformatf("disp %0d len", i),       len, disp_tbl[i].len);
            chk($sformatf("disp %0d plane_sel", i), ps,  disp_tbl[i].ps);
            chk($sformatf("disp %0d row_addr", i),  ra,  disp_tbl[i].ra);
        end

        // Frame period and wrap back to row 0 plane 0.
        guard = 0;
        while (frame_done !== 1'b1 && guard < 400) begin
            step();
            guard++;
        end
        chk("frame_done seen", frame_done, 1);
        step();
        n = 1;
        chk("frame_done one cycle", frame_done, 0);
        chk("wrap mem_addr",        mem_addr,   0);
        chk("wrap plane_sel",       plane_sel,  0);
        while (frame_done !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        chk("frame period", n, 208);

        // Drop enable in row 1 plane 2 display; plane finishes, then idle; resume at row 1 plane 3.
        guard = 0;
        while (!(panel_oe_n === 1'b0 && row_addr === 1'b1 && plane_sel === 2'd2) && guard < 400) begin
            step();
            guard++;
        end
        chk("found row1 plane2", {row_addr, plane_sel}, 3'b110);
        enable = 1'b0;
        len = 1;
        step();
        while (panel_oe_n === 1'b0 && len < 100) begin
            len++;
            step();
        end
        chk("pause disp len", len, 16);
        chk("pause NEXT busy", busy, 1);
        step();
        chk("pause idle busy", busy, 0);
        repeat (3) step();
        chk("pause idle hold", {busy, panel_oe_n}, 2'b01);
        chk("pause plane_sel", plane_sel, 3);
        enable = 1'b1;
        step();
        chk("resume busy",      busy,      1);
        chk("resume mem_addr",  mem_addr,  4);
        chk("resume plane_sel", plane_sel, 3);
        step();
        step();
        chk("resume t=2 panel_clk", panel_clk, 1);
        chk("resume t=2 rgb",       rgb,       pix(4, 3));

        // Async reset in the middle of SHIFT (t=5).
        step();
        step();
        step();
        chk("pre-reset mem_addr t=5", mem_addr, 6);
        enable = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("async rst panel_clk",  panel_clk,  0);
        chk("async rst panel_oe_n", panel_oe_n, 1);
        chk("async rst panel_lat",  panel_lat,  0);
        chk("async rst mem_addr",   mem_addr,   0);
        chk("async rst plane_sel",  plane_sel,  0);
        chk("async rst row_addr",   row_addr,   0);
        chk("async rst busy",       busy,       0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        chk("post-reset idle", {busy, panel_oe_n, panel_lat}, 3'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
